// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe -- pipelined RISC-V immediate generator for the decode stage.
//
// Decodes the immediate, format class and legality of a 32-bit instruction
// word. The result is registered with a valid/ready handshake. A 1-entry skid
// buffer lets upstream keep streaming while the consumer stalls.
//
// Optional feature: define IMMGEN_CSR_EN to decode SYSTEM (1110011) opcodes
// as CSR / CSR-immediate forms. Left undefined, SYSTEM is treated as plain
// I-type.
//
// Parameters:
//   XLEN  - immediate width (32 or 64)
//   TAG_W - sideband tag width
//   CNT_W - illegal-instruction counter width
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   - input handshake (in_ready low while skid is full)
//   in_instr, in_tag      - instruction word and its sideband tag
//   out_valid / out_ready - output handshake
//   out_imm, out_fmt      - immediate and format
//                           (0=R 1=I 2=S 3=B 4=U 5=J 6=CSR 7=NONE)
//   out_illegal, out_tag  - illegal-opcode flag and tag of the output instruction
//   illegal_count         - saturating count of illegal instructions handed off
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_CSR  = 3'd6;
  localparam logic [2:0] FMT_NONE = 3'd7;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } dec_t;

  // Every immediate fits in 32 bits; widen by sign extension to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  state_t state, state_next;
  dec_t   dec;
  logic   accept;
  logic   skid_valid;

  logic [XLEN-1:0]  skid_imm;
  logic [2:0]       skid_fmt;
  logic             skid_illegal;
  logic [TAG_W-1:0] skid_tag;

  // ---------------- combinational decode ----------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};

  always_comb begin
    // NOTE: every field gets a default first so no path leaves it unassigned (no latch).
    dec.imm     = '0;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    case (opcode)
      7'b0010011: begin
        dec.fmt = FMT_I;
        if (funct3 == 3'b001 || funct3 == 3'b101)
          dec.imm = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
        else
          dec.imm = sext32(imm_i);
      end
      7'b0000011, 7'b1100111: begin
        dec.fmt = FMT_I;
        dec.imm = sext32(imm_i);
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec.fmt = FMT_I;
          dec.imm = sext32(imm_i);
        end else begin
          dec.illegal = 1'b1;
        end
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.imm = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0});
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        dec.imm = sext32({in_instr[31:12], 12'b0});
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        dec.imm = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0});
      end
      7'b0110011: dec.fmt = FMT_R;
      7'b0111011: begin
        if (XLEN == 64) dec.fmt = FMT_R;
        else            dec.illegal = 1'b1;
      end
      7'b1110011: begin
`ifdef IMMGEN_CSR_EN
        if (funct3[2] && funct3[1:0] != 2'b00) begin
          dec.fmt = FMT_CSR;                       // csrr*i: uimm in rs1 field
          dec.imm = XLEN'(in_instr[19:15]);
        end else if (funct3[1:0] != 2'b00) begin
          dec.fmt = FMT_I;                         // csrr*: CSR address
          dec.imm = XLEN'(in_instr[31:20]);
        end else begin
          dec.fmt = FMT_I;                         // ecall/ebreak/mret...
        end
`else
        dec.fmt = FMT_I;
        dec.imm = sext32(imm_i);
`endif
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // ---------------- handshake FSM ----------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = FULL;
      FULL: begin
        if (accept && !out_ready)      state_next = SKID;
        else if (!accept && out_ready) state_next = EMPTY;
      end
      SKID:    if (out_ready) state_next = FULL;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    out_valid  = (state != EMPTY);
    skid_valid = (state == SKID);
    in_ready   = !skid_valid;
  end

  assign accept = in_valid && in_ready;

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_imm       <= '0;
      out_fmt       <= FMT_NONE;
      out_illegal   <= 1'b0;
      out_tag       <= '0;
      illegal_count <= '0;
    end else begin
      if (out_valid && out_ready && out_illegal && illegal_count != CNT_MAX)
        illegal_count <= illegal_count + 1'b1;

      if (state == SKID && out_ready) begin
        out_imm     <= skid_imm;
        out_fmt     <= skid_fmt;
        out_illegal <= skid_illegal;
        out_tag     <= skid_tag;
      end else if (accept && (state == EMPTY || out_ready)) begin
        out_imm     <= dec.imm;
        out_fmt     <= dec.fmt;
        out_illegal <= dec.illegal;
        out_tag     <= in_tag;
      end
    end
  end

  // NOTE: skid payload has no reset; it is only ever read while the FSM says it is valid.
  always_ff @(posedge clk) begin
    if (state == FULL && accept && !out_ready) begin
      skid_imm     <= dec.imm;
      skid_fmt     <= dec.fmt;
      skid_illegal <= dec.illegal;
      skid_tag     <= in_tag;
    end
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised RV immediate generator for the per-core decode stage.
- Decodes immediates for all RV32I/RV64I base formats, with correct sign extension for S-type and load.
- Registered output with valid/ready handshake and a 1-entry skid buffer, so decode backpressure never drops instructions.
- Classifies the format, flags illegal opcodes and keeps a saturating illegal-instruction counter per core.

Parameters:
- XLEN, 32, immediate/output width; legal values 32 or 64.
- TAG_W, 8, width of the sideband tag (PC index / core id) carried alongside each instruction.
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present on in_instr
- in_ready  out  1  block can accept; equals !skid_valid
- in_instr  in  32  instruction word
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  out_imm/out_fmt/out_illegal/out_tag valid
- out_ready  in  1  consumer accepts output
- out_imm  out  XLEN  decoded immediate
- out_fmt  out  3  0=R,1=I,2=S,3=B,4=U,5=J,6=CSR,7=NONE
- out_illegal  out  1  unrecognised opcode
- out_tag  out  TAG_W  tag of the output instruction
- illegal_count  out  CNT_W  saturating count of illegal instructions emitted

Behaviour:
- Reset (synchronous, highest priority): out_valid=0, skid_valid=0, out_imm=0, out_fmt=7, out_illegal=0, out_tag=0, illegal_count=0. Inputs are ignored while reset=1. in_ready=1 after reset.
- Decode is combinational on in_instr, by opcode [6:0]:
  - 0010011 with funct3 001/101: fmt I, imm = zero-extended shamt. Shamt is [24:20] for XLEN=32, [25:20] for XLEN=64.
  - 0010011 other funct3, 0000011, 1100111, 0011011 (XLEN=64 only): fmt I, imm = sext(instr[31:20]).
  - 0100011: fmt S, imm = sext({[31:25],[11:7]}).
  - 1100011: fmt B, imm = sext({[31],[7],[30:25],[11:8],0}).
  - 0110111, 0010111: fmt U, imm = sext({[31:12],12'b0}) to XLEN.
  - 1101111: fmt J, imm = sext({[31],[19:12],[20],[30:21],0}).
  - 0110011, 0111011 (XLEN=64 only): fmt R, imm=0.
  - 1110011: see Optional Feature.
  - Anything else, including W-opcodes when XLEN=32: fmt 7, imm=0, illegal=1.
- Latency: exactly 1 cycle from accept (in_valid & in_ready) to out_valid when the output register is free.
- States:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1, skid empty).
  - SKID (out_valid=1, skid full, in_ready=0).
- Transitions:
  - EMPTY --accept--> FULL.
  - FULL --accept & out_ready--> FULL (new data).
  - FULL --accept & !out_ready--> SKID (input captured into skid).
  - FULL --!accept & out_ready--> EMPTY.
  - SKID --out_ready--> FULL (skid moves to output).
- Output fields hold stable while out_valid & !out_ready. Order is strictly preserved.
- illegal_count increments by 1 on each output handshake (out_valid & out_ready) with out_illegal=1. It holds at 2^CNT_W-1 and never wraps.
- out_imm sign extension is to the full XLEN.

Optional Feature:
- Macro IMMGEN_CSR_EN.
- Defined: opcode 1110011 with funct3 101/110/111 gives fmt CSR, imm = zext(instr[19:15]). funct3 001/010/011 gives fmt I, imm = zext(instr[31:20]). funct3 000 gives fmt I, imm=0.
- Undefined: opcode 1110011 is always fmt I, imm = sext(instr[31:20]).

Test Plan:
- XLEN=32, accept 0xFFF00093 (addi -1) with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1.
- Accept 0xFE20AE23 (sw x2,-4(x1)) -> out_imm=0xFFFFFFFC, out_fmt=2, out_illegal=0.
- out_ready=0, present tags 1,2,3 on consecutive cycles -> tag1 on output, tag2 in skid, in_ready=0 so tag3 is held. Raise out_ready -> tags 1,2,3 emerge in order, none dropped or duplicated.
- CNT_W=2, send 0x0000007F five times -> each out_illegal=1, out_fmt=7, out_imm=0; illegal_count goes 1,2,3,3,3.
- XLEN=64: 0x800000B7 -> out_imm=0xFFFFFFFF80000000. 0x03F09093 (slli x1,x1,63) -> out_imm=63. 0x0000003B at XLEN=32 -> out_illegal=1.
- Reset asserted for 1 cycle while in SKID state -> next cycle out_valid=0, in_ready=1, illegal_count=0. With IMMGEN_CSR_EN, 0x300FD073 -> out_fmt=6, out_imm=31.
